// File: rtl/data_capture_pkg.sv
// Shared types and defaults for the req/ack capture receiver and its output FIFO.
package data_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2
  } rx_state_e;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_TIMEOUT_CYC = 1024;
  localparam int DEF_CNT_W       = 16;

  // Pointer width including the extra wrap bit used to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/data_capture_rx_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is read straight from storage.
module sync_fifo
  import data_capture_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic [ptr_w(DEPTH)-1:0]  count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/data_capture_rx.sv
// Receive side of a 4-phase req/ack CDC handshake: captures data_in into a FIFO and acks.
module data_capture_rx
  import data_capture_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_av_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic              data_ack,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  capture_cnt,
  output logic              err_timeout
);

  localparam int            PW       = ptr_w(FIFO_DEPTH);
  localparam int            TW       = $clog2(TIMEOUT_CYC);
  localparam logic [PW-1:0] DEPTH_V  = PW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  rx_state_e     state;
  rx_state_e     state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [PW-1:0] fifo_count;
  logic          fifo_empty;
  logic          push;

  assign push      = (state == CAPTURE);
  assign out_valid = !fifo_empty;

  // data_in is sampled one cycle after req is seen, giving the async bus time to settle.
  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (data_in),
    .pop     (out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (data_av_sync && (fifo_count < DEPTH_V)) state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     if (!data_av_sync) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      data_ack    <= 1'b0;
      capture_cnt <= '0;
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_ack <= (state_nxt == ACK);
      if (push) capture_cnt <= capture_cnt + 1'b1;
      // Counter holds at its last value once the sticky error has fired.
      if ((state == ACK) && data_av_sync) begin
        if (tmo_cnt == TMO_LAST) err_timeout <= 1'b1;
        else                     tmo_cnt     <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_capture_rx.sv
// Directed bench for data_capture_rx: handshake timing, ordering, back-pressure, timeout, reset, wrap.
module tb_data_capture_rx;

  localparam int DATA_W      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_av_sync;
  logic [DATA_W-1:0] data_in;
  logic              data_ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [CNT_W-1:0]  capture_cnt;
  logic              err_timeout;

  int vectors     = 0;
  int miscompares = 0;

  data_capture_rx #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_av_sync (data_av_sync),
    .data_in      (data_in),
    .data_ack     (data_ack),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .capture_cnt  (capture_cnt),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise req with word w, wait (bounded) for ack, optionally check latency/head, then drop req.
  task automatic send(input logic [7:0] w, input bit chk_timing, input string tag);
    int n;
    data_in      = w;
    data_av_sync = 1'b1;
    n = 0;
    while (!data_ack && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ack"}, {31'b0, data_ack}, 32'd1);
    if (chk_timing) begin
      chk({tag, "_lat"}, n, 32'd2);
      chk({tag, "_head"}, {24'b0, out_data}, {24'b0, w});
    end
    data_av_sync = 1'b0;
    step();
    chk({tag, "_ack_low"}, {31'b0, data_ack}, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    data_av_sync = 1'b0;
    data_in      = '0;
    out_ready    = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_ack",   {31'b0, data_ack},    32'd0);
    chk("rst_valid", {31'b0, out_valid},   32'd0);
    chk("rst_cnt",   {28'b0, capture_cnt}, 32'd0);
    chk("rst_err",   {31'b0, err_timeout}, 32'd0);

    // Single word, req held for 10 cycles.
    data_in      = 8'hA5;
    data_av_sync = 1'b1;
    step();
    chk("t1_ack_e1",   {31'b0, data_ack},  32'd0);
    chk("t1_valid_e1", {31'b0, out_valid}, 32'd0);
    step();
    chk("t1_ack_e2",   {31'b0, data_ack},    32'd1);
    chk("t1_valid_e2", {31'b0, out_valid},   32'd1);
    chk("t1_data",     {24'b0, out_data},    32'hA5);
    chk("t1_cnt",      {28'b0, capture_cnt}, 32'd1);
    for (int i = 0; i < 8; i++) step();
    chk("t1_ack_hold", {31'b0, data_ack}, 32'd1);
    data_av_sync = 1'b0;
    step();
    chk("t1_ack_drop", {31'b0, data_ack},    32'd0);
    chk("t1_err",      {31'b0, err_timeout}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t1_popped", {31'b0, out_valid}, 32'd0);

    // Back-to-back words with a consumer that is always ready.
    out_ready = 1'b1;
    send(8'h01, 1'b1, "t2_w1");
    send(8'h02, 1'b1, "t2_w2");
    send(8'h03, 1'b1, "t2_w3");
    send(8'h04, 1'b1, "t2_w4");
    chk("t2_cnt",   {28'b0, capture_cnt}, 32'd5);
    chk("t2_empty", {31'b0, out_valid},   32'd0);

    // Fill the FIFO, then a fifth req must wait for a pop.
    out_ready = 1'b0;
    send(8'h10, 1'b0, "t3_w1");
    send(8'h11, 1'b0, "t3_w2");
    send(8'h12, 1'b0, "t3_w3");
    send(8'h13, 1'b0, "t3_w4");
    data_in      = 8'h14;
    data_av_sync = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t3_blocked_ack", {31'b0, data_ack},    32'd0);
    chk("t3_blocked_cnt", {28'b0, capture_cnt}, 32'd9);
    chk("t3_head",        {24'b0, out_data},    32'h10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(8'h14, 1'b0, "t3_w5");
    chk("t3_cnt", {28'b0, capture_cnt}, 32'd10);
    out_ready = 1'b1;
    chk("t3_d11", {24'b0, out_data}, 32'h11);
    step();
    chk("t3_d12", {24'b0, out_data}, 32'h12);
    step();
    chk("t3_d13", {24'b0, out_data}, 32'h13);
    step();
    chk("t3_d14", {24'b0, out_data}, 32'h14);
    step();
    chk("t3_drained", {31'b0, out_valid}, 32'd0);

    // Timeout: req held high after ack.
    data_in      = 8'h5A;
    data_av_sync = 1'b1;
    step();
    step();
    chk("t4_ack", {31'b0, data_ack}, 32'd1);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) step();
    chk("t4_err_pre", {31'b0, err_timeout}, 32'd0);
    step();
    chk("t4_err_set", {31'b0, err_timeout}, 32'd1);
    data_av_sync = 1'b0;
    step();
    chk("t4_ack_drop",   {31'b0, data_ack},    32'd0);
    chk("t4_err_sticky", {31'b0, err_timeout}, 32'd1);
    step();
    chk("t4_err_sticky2", {31'b0, err_timeout}, 32'd1);
    chk("t4_cnt",         {28'b0, capture_cnt}, 32'd11);

    // Reset while ack is high.
    out_ready    = 1'b0;
    data_in      = 8'h77;
    data_av_sync = 1'b1;
    step();
    step();
    chk("t5_ack_pre", {31'b0, data_ack}, 32'd1);
    rst          = 1'b1;
    data_av_sync = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_ack",   {31'b0, data_ack},    32'd0);
    chk("t5_valid", {31'b0, out_valid},   32'd0);
    chk("t5_cnt",   {28'b0, capture_cnt}, 32'd0);
    chk("t5_err",   {31'b0, err_timeout}, 32'd0);
    step();
    chk("t5_idle_ack", {31'b0, data_ack}, 32'd0);

    // Push and pop on the same edge with one word held.
    send(8'h20, 1'b1, "t6_w1");
    data_in      = 8'h21;
    data_av_sync = 1'b1;
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_ack",   {31'b0, data_ack},  32'd1);
    chk("t6_valid", {31'b0, out_valid}, 32'd1);
    chk("t6_head",  {24'b0, out_data},  32'h21);
    chk("t6_count", {29'b0, dut.u_fifo.count}, 32'd1);
    data_av_sync = 1'b0;
    step();
    chk("t6_cnt2", {28'b0, capture_cnt}, 32'd2);

    // Capture counter wrap (4-bit here): 13 more reach 15, one more wraps to 0.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) send(8'h30 + 8'(i), 1'b0, "t6_fill");
    chk("t6_cnt_max", {28'b0, capture_cnt}, 32'd15);
    send(8'h3D, 1'b1, "t6_wrapw");
    chk("t6_cnt_wrap", {28'b0, capture_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
